shift_seq_ctrl: RTL
===================

# shift_seq_ctrl

Sequencer for a WIDTH-bit shift register built from D flip-flop cells. It accepts a parallel word over a valid/ready handshake and shifts it out serially on `sout`, one bit per clock. At the same time it shifts serial data from `sin` into the same register and presents the captured word on `dout` with a one-cycle `dout_valid` strobe. It is the control layer that loads, clocks and drains the flip-flop chain for the serial-link experiments.

## Interface
- `WIDTH`, default 8: word length; legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts MSB out first and takes `sin` in at the LSB; 0 shifts LSB out first and takes `sin` in at the MSB.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `r`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WIDTH  parallel word to transmit.
- `abort`  in  1  cancels a transfer in progress.
- `sin`  in  1  serial input, sampled on each shift edge.
- `sout`  out  1  serial output.
- `shift_en`  out  1  high during every shift cycle.
- `dout`  out  WIDTH  last captured word.
- `dout_valid`  out  1  one-cycle strobe marking a new `dout`.
- `busy`  out  1  high when not in IDLE.
- `bit_cnt`  out  CNT_W  shift cycles completed; CNT_W = clog2(WIDTH)+1.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: `shift_en`=1.
  - DONE: `dout_valid`=1.
- IDLE -> SHIFT on `in_valid & in_ready`.
  - `sr <= in_data`, `bit_cnt <= 0`.
- SHIFT, every edge:
  - MSB_FIRST=1: `sr <= {sr[W-2:0], sin}`.
  - MSB_FIRST=0: `sr <= {sin, sr[W-1:1]}`.
  - `bit_cnt` increments by 1.
- SHIFT -> DONE on the edge where `bit_cnt == WIDTH-1`.
  - That edge performs the final shift.
  - `dout` is loaded with the post-shift register value.
- DONE -> IDLE unconditionally on the next edge.
- Combinational outputs:
  - `sout` = `sr[W-1]` (MSB_FIRST=1) or `sr[0]` (MSB_FIRST=0) in SHIFT; 0 in all other states.
  - `in_ready` = (state==IDLE) & ~`r`.
  - `busy` = (state != IDLE).
- `abort`:
  - In SHIFT: next state is IDLE, `sr` and `bit_cnt` cleared, `dout` unchanged, no `dout_valid`.
  - In IDLE (including the same cycle as `in_valid`): ignored, so the word is accepted.
  - In DONE: ignored, and the strobe still fires.
- `in_valid` while `in_ready`=0 is ignored; the upstream block holds the word until it sees `in_ready`.
- Loopback (`sout` tied to `sin`) must return `dout == in_data` for both MSB_FIRST settings.

## Timing
- Reset values while `r` is high, applied asynchronously:
  - state IDLE, `sr`=0, `dout`=0, `bit_cnt`=0.
  - `dout_valid`=0, `sout`=0, `shift_en`=0, `busy`=0, `in_ready`=0.
- `in_ready` rises in the first cycle after `r` deasserts.
- Accept at edge k:
  - SHIFT occupies cycles k+1..k+WIDTH.
  - During cycle k+1, `sout` is the first bit of `in_data`.
  - `sin` is sampled at edges k+1..k+WIDTH.
- `dout`/`dout_valid` are valid in the cycle after edge k+WIDTH. `in_ready` is high after edge k+WIDTH+1.
- Maximum throughput is one word per WIDTH+2 cycles. No pipelining across words.
- `r` asserted mid-SHIFT: transfer lost, all outputs at reset values immediately, no partial `dout`.

## Structure
- Shared package/header `shift_seq_pkg` holds:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - the CNT_W clog2 function.
- One sub-module, `shift_reg_core`:
  - WIDTH-bit register built from async-reset D flip-flop cells.
  - Inputs: `load`, `shift`, `load_data`, `sin`, MSB_FIRST.
  - Output: the register contents.
- `shift_seq_ctrl` holds the FSM, `bit_cnt`, the `dout` register and the handshake logic.

## Test plan
- Loopback, WIDTH=8, MSB_FIRST=1, `in_data`=8'hA5:
  - `sout` sequence is 1,0,1,0,0,1,0,1.
  - `dout`=8'hA5 with `dout_valid` 9 cycles after the accept edge.
- `sin` held 1, `in_data`=8'h00:
  - `sout` is all 0.
  - `dout`=8'hFF; `shift_en` high for exactly 8 cycles.
- `abort` in the 3rd SHIFT cycle:
  - No `dout_valid`; `dout` keeps its previous value.
  - `in_ready`=1 in the next cycle; `bit_cnt`=0.
- `r` pulsed mid-SHIFT (4th cycle):
  - All outputs at reset values immediately.
  - A fresh word afterwards completes normally.
- `in_valid` held high with two words, WIDTH=8:
  - Accepts occur exactly 10 cycles apart.
  - `in_ready` is low for the 9 cycles between them.
- WIDTH=4, MSB_FIRST=0, loopback, `in_data`=4'b0001:
  - `sout` sequence is 1,0,0,0.
  - `dout`=4'b0001.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer: FSM encodings and
// the bit-counter width helpers.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Ceiling log2 for small positive values (word lengths up to 32).
  function automatic int clog2(input int v);
    int res;
    res = 0;
    for (int i = 0; i < 6; i++) begin
      if ((1 << i) < v) res = i + 1;
    end
    return res;
  endfunction

  function automatic int cnt_w(input int width);
    return clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit shift register made of async-reset D flip-flop cells with
// synchronous clear, parallel load and one-bit shift toward the exit end.
module shift_reg_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic shift_in;
      logic q_bit;

      // MSB-first enters at bit 0 and moves upward; LSB-first enters at the top.
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_entry
          assign shift_in = sin;
        end else begin : g_chain
          assign shift_in = q[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH-1) begin : g_entry
          assign shift_in = sin;
        end else begin : g_chain
          assign shift_in = q[gi+1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_bit <= 1'b0;
        end else if (clear) begin
          q_bit <= 1'b0;
        end else if (load) begin
          q_bit <= load_data[gi];
        end else if (shift) begin
          q_bit <= shift_in;
        end
      end

      assign q[gi] = q_bit;
    end
  endgenerate

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load/shift/drain sequencer around shift_reg_core: accepts a word, shifts it
// out on sout while capturing sin, then strobes the captured word on dout.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  input  logic             sin,
  output logic             sout,
  output logic             shift_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [WIDTH-1:0]   sr;
  logic [WIDTH-1:0]   sr_shifted;
  logic               sr_load, sr_shift, sr_clear;

  shift_reg_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst       (r),
    .clear     (sr_clear),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (in_data),
    .sin       (sin),
    .q         (sr)
  );

  // Register value after the current edge's shift; captured into dout on the last shift.
  generate
    if (MSB_FIRST) begin : g_next_msb
      assign sr_shifted = {sr[WIDTH-2:0], sin};
    end else begin : g_next_lsb
      assign sr_shifted = {sin, sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    dout_d    = dout_q;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_clear  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = SHIFT;
          sr_load   = 1'b1;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          sr_clear  = 1'b1;
          bit_cnt_d = '0;
        end else begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = DONE;
            dout_d  = sr_shifted;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sout = 1'b0;
    if (state_q == SHIFT) begin
      sout = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    end
  end

  assign in_ready   = (state_q == IDLE) & ~r;
  assign shift_en   = (state_q == SHIFT);
  assign dout_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign dout       = dout_q;
  assign bit_cnt    = bit_cnt_q;

endmodule
